// File: rtl/dp_ram_param.sv
// Dual-port byte-enabled RAM: two symmetric read/write ports, registered reads, write-first across ports.
// Optional power-up zero sweep is compiled in with `define DP_RAM_PARAM_CLEAR_EN.
module dp_ram_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int BE_W  = DATA_W / 8,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [BE_W-1:0]   be_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [BE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic              collision,
  output logic              busy,
  output logic              state_dbg
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  // Access protocol: a port request is en_x=1 qualified by busy=0; there is no
  // back-pressure. we_x selects write (1) or read (0); a read answers with
  // vld_x=1 and dout_x exactly one edge later.
  logic wr_a, wr_b, rd_a, rd_b, same_addr;
  assign wr_a      = en_a &  we_a & ~busy;
  assign wr_b      = en_b &  we_b & ~busy;
  assign rd_a      = en_a & ~we_a & ~busy;
  assign rd_b      = en_b & ~we_b & ~busy;
  assign same_addr = (addr_a == addr_b);

`ifdef DP_RAM_PARAM_CLEAR_EN
  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_addr <= '0;
    else if (state == S_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_addr == {ADDR_W{1'b1}}) state_nxt = S_READY;
  end

  // Sweep writes are held off while reset is asserted so reset never touches memory.
  always_comb begin
    busy      = (state == S_CLEAR);
    clr_we    = (state == S_CLEAR) & rst_n;
    state_dbg = (state == S_READY);
  end
`else
  assign busy      = 1'b0;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign state_dbg = 1'b1;
`endif

  // Port A is applied last so it owns lanes enabled on both ports at one address.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (wr_b) begin
      for (int i = 0; i < BE_W; i++)
        if (be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
    if (wr_a) begin
      for (int i = 0; i < BE_W; i++)
        if (be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
    end
  end

  // Write-first bypass: a reader sees the other port's written lanes this cycle.
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  always_comb begin
    rd_data_a = mem[addr_a];
    rd_data_b = mem[addr_b];
    for (int i = 0; i < BE_W; i++) begin
      if (wr_b && same_addr && be_b[i]) rd_data_a[8*i +: 8] = din_b[8*i +: 8];
      if (wr_a && same_addr && be_a[i]) rd_data_b[8*i +: 8] = din_a[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a    <= '0;
      dout_b    <= '0;
      vld_a     <= 1'b0;
      vld_b     <= 1'b0;
      collision <= 1'b0;
    end else begin
      vld_a     <= rd_a;
      vld_b     <= rd_b;
      collision <= wr_a & wr_b & same_addr;
      if (rd_a) dout_a <= rd_data_a;
      if (rd_b) dout_b <= rd_data_b;
    end
  end

endmodule

// File: doc/dp_ram_param.md
DP_RAM_PARAM -- requirements
Module: dp_ram_param

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Derived constant BE_W = DATA_W/8, the number of byte lanes.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en_a / en_b  in  1  port access enable.
REQ-007 we_a / we_b  in  1  write (1) or read (0), qualified by en_x.
REQ-008 be_a / be_b  in  BE_W  byte-lane write enables; bit i selects bits [8i+7:8i].
REQ-009 addr_a / addr_b  in  ADDR_W  word address.
REQ-010 din_a / din_b  in  DATA_W  write data.
REQ-011 dout_a / dout_b  out  DATA_W  registered read data.
REQ-012 vld_a / vld_b  out  1  read-data-valid strobe.
REQ-013 collision  out  1  same-address write/write strobe.
REQ-014 busy  out  1  initialisation in progress; all accesses are ignored while high.

Function
REQ-015 Both ports are symmetric read/write ports and SHALL be serviced in the same cycle.
REQ-016 A write is accepted when en_x=1, we_x=1 and busy=0; only lanes with be_x[i]=1 are updated.
REQ-017 A read is accepted when en_x=1, we_x=0 and busy=0; mem[addr_x] SHALL appear on dout_x after the next edge, with vld_x=1 for exactly that one cycle.
REQ-018 dout_x SHALL hold its last value when no read is accepted; outputs are never tri-stated.
REQ-019 A write on port x SHALL NOT change dout_x or pulse vld_x.
REQ-020 Cross-port read-during-write to the same address SHALL be write-first: the reader returns the new data in written lanes and old data in unwritten lanes.
REQ-021 When both ports write the same address in one cycle, lanes enabled on both ports SHALL take din_a; lanes enabled on B only SHALL take din_b.
REQ-022 The condition in REQ-021 SHALL drive collision=1 for exactly the following cycle, including when the byte-lane sets do not overlap.
REQ-023 Different-address simultaneous accesses SHALL be fully independent.
REQ-024 Any address in 0..DEPTH-1 is valid; no wrap-around or out-of-range case exists.
REQ-025 The control FSM has two states: CLEAR (busy=1) and READY (busy=0).
REQ-026 In CLEAR, an ADDR_W-bit counter starting at 0 SHALL write all-zero to mem[counter] each cycle; after writing DEPTH-1 the FSM SHALL move to READY on the next edge (DEPTH cycles of busy).
REQ-027 In CLEAR, en_x/we_x SHALL be ignored: no writes, vld_x=0, collision=0.
REQ-028 READY is terminal until the next reset.

Reset
REQ-029 While rst_n=0: dout_a=dout_b=0, vld_a=vld_b=0, collision=0, clear counter=0.
REQ-030 Reset SHALL enter CLEAR when clear is compiled in, and READY otherwise; busy follows the state.
REQ-031 Reset asserted mid-CLEAR SHALL restart the sweep from address 0 on release.
REQ-032 Memory contents are not altered by reset itself.

Configuration
REQ-033 Macro DP_RAM_PARAM_CLEAR_EN: when defined, the CLEAR FSM is compiled in per REQ-025..REQ-027 and REQ-030.
REQ-034 Without DP_RAM_PARAM_CLEAR_EN: no counter or FSM; busy is tied 0; contents after power-up are undefined; reads are accepted from the first edge after reset release.

Verification
REQ-035 CLEAR_EN defined, ADDR_W=5: release reset -> busy=1 for exactly 32 cycles; then a read of every address returns 0x00000000 with vld pulsing.
REQ-036 Port A writes 0xDEADBEEF to addr 3 with be=4'b1111, then port B reads addr 3 -> dout_b=0xDEADBEEF and vld_b=1 one cycle after the read.
REQ-037 mem[7]=0x11223344; in the same cycle A writes 0xAABBCCDD with be=4'b0011 and B reads addr 7 -> dout_b=0x1122CCDD next cycle.
REQ-038 Both ports write addr 9: A 0xAAAAAAAA with be=4'b0110, B 0x55555555 with be=4'b1111 -> mem[9]=0x55AAAA55 and collision=1 for one cycle.
REQ-039 Reset asserted at sweep address 10 and released -> busy=1 for a full 32 further cycles and the sweep restarts at 0; reads issued while busy -> vld=0 and no memory change.
